// File: rtl/sweep_sync_controller_pkg.sv
// Shared definitions for the heat-grid sweep synchronisation logic:
// controller state encoding, default grid sizing and counter helpers.
package sweep_sync_controller_pkg;

  localparam int NUM_COLS_DEF = 32;
  localparam int CNT_W        = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_ALL = 3'd1,
    ST_PULSE    = 3'd2,
    ST_GUARD    = 3'd3,
    ST_PAUSE    = 3'd4,
    ST_HALT     = 3'd5
  } state_e;

  // Saturating increment: a stuck sweep must never wrap its cycle count back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/sweep_sync_controller_col_done_reduce.sv
// Column-done reduction: turns the last-active-column index into a participation
// mask and ANDs the masked done flags. Purely combinational; also used for DMA column masks.
module col_done_reduce
  import sweep_sync_controller_pkg::*;
#(
  parameter int NUM_COLS = NUM_COLS_DEF
) (
  input  logic [7:0]          width_i,
  input  logic [NUM_COLS-1:0] col_flag_i,
  output logic [NUM_COLS-1:0] active_mask_o,
  output logic                all_done_o
);

  always_comb begin
    for (int i = 0; i < NUM_COLS; i++) begin
      active_mask_o[i] = (i <= int'(width_i));
    end
    all_done_o = &(col_flag_i | ~active_mask_o);
  end

endmodule

// File: rtl/sweep_sync_controller.sv
// Global sweep barrier for the column engines: waits for every active column's done flag,
// then issues one start pulse per time step; counts, pauses, halts and watches for stalls.
module sweep_sync_controller
  import sweep_sync_controller_pkg::*;
#(
  parameter int NUM_COLS       = NUM_COLS_DEF,
  parameter int GUARD_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [7:0]          width,
  input  logic [31:0]         max_iter,
  input  logic [NUM_COLS-1:0] col_flag,
  output logic                start,
  output logic [31:0]         iter_count,
  output logic [31:0]         sweep_cycles,
  output logic                busy,
  output logic                done,
  output logic                timeout
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cyc_cnt_q, cyc_cnt_d;
  logic [CNT_W-1:0]   guard_cnt_q, guard_cnt_d;
  logic [CNT_W-1:0]   iter_q, iter_d;
  logic [CNT_W-1:0]   sweep_q, sweep_d;
  logic               timeout_q, timeout_d;
  logic               start_q;
  logic               run_q;
  logic               all_done;
  logic [NUM_COLS-1:0] active_mask_unused;

  col_done_reduce #(
    .NUM_COLS (NUM_COLS)
  ) u_reduce (
    .width_i       (width),
    .col_flag_i    (col_flag),
    .active_mask_o (active_mask_unused),
    .all_done_o    (all_done)
  );

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    state_d     = state_q;
    cyc_cnt_d   = cyc_cnt_q;
    guard_cnt_d = guard_cnt_q;
    iter_d      = iter_q;
    sweep_d     = sweep_q;
    timeout_d   = timeout_q;

    unique case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_WAIT_ALL;
      end
      ST_WAIT_ALL: begin
        cyc_cnt_d = sat_inc(cyc_cnt_q);
        if (all_done) begin
          iter_d  = iter_q + CNT_W'(1);
          sweep_d = sat_inc(cyc_cnt_q);
          if (max_iter != '0 && iter_q + CNT_W'(1) == max_iter) state_d = ST_HALT;
          else if (!run)                                         state_d = ST_PAUSE;
          else                                                   state_d = ST_PULSE;
        end else if (TIMEOUT_CYCLES != 0 && cyc_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = ST_HALT;
        end
      end
      ST_PULSE: begin
        guard_cnt_d = '0;
        state_d     = (GUARD_CYCLES == 0) ? ST_WAIT_ALL : ST_GUARD;
      end
      ST_GUARD: begin
        cyc_cnt_d   = sat_inc(cyc_cnt_q);
        guard_cnt_d = guard_cnt_q + CNT_W'(1);
        if (guard_cnt_q == CNT_W'(GUARD_CYCLES - 1)) state_d = ST_WAIT_ALL;
      end
      ST_PAUSE: begin
        if (run) state_d = ST_PULSE;
      end
      ST_HALT: begin
        // Restart only on a fresh run edge so a level left high cannot loop past the limit.
        if (run && !run_q) begin
          iter_d    = '0;
          timeout_d = 1'b0;
          state_d   = ST_PULSE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_WAIT_ALL && state_q != ST_WAIT_ALL) cyc_cnt_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cyc_cnt_q   <= '0;
      guard_cnt_q <= '0;
      iter_q      <= '0;
      sweep_q     <= '0;
      timeout_q   <= 1'b0;
      start_q     <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_cnt_q   <= cyc_cnt_d;
      guard_cnt_q <= guard_cnt_d;
      iter_q      <= iter_d;
      sweep_q     <= sweep_d;
      timeout_q   <= timeout_d;
      start_q     <= (state_d == ST_PULSE);
      run_q       <= run;
    end
  end

  assign start        = start_q;
  assign iter_count   = iter_q;
  assign sweep_cycles = sweep_q;
  assign timeout      = timeout_q;
  assign busy         = (state_q == ST_WAIT_ALL) || (state_q == ST_PULSE) || (state_q == ST_GUARD);
  assign done         = (state_q == ST_HALT);

endmodule
